// File: rtl/alarm_controller_if.sv
// alarm_controller_if: sensor inputs, parameter-store handshake and indicator outputs.
`default_nettype none

interface alarm_controller_if;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       one_hz_enable;
  logic [3:0] value;
  logic [1:0] interval;
  logic       siren;
  logic       status_led;
  logic [2:0] state;

  modport master (
    output ignition, driver_door, passenger_door, one_hz_enable, value,
    input  interval, siren, status_led, state
  );

  modport slave (
    input  ignition, driver_door, passenger_door, one_hz_enable, value,
    output interval, siren, status_led, state
  );
endinterface

`default_nettype wire

// File: rtl/alarm_controller.sv
// alarm_controller: vehicle alarm FSM with a tick-driven countdown, siren and status LED.
// Revision: 1.0
`default_nettype none

module alarm_controller (
  input  wire logic         clock,
  input  wire logic         reset,
  alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ARMED      = 3'b000,
    TRIGGERED  = 3'b001,
    ALARM      = 3'b010,
    DISARMED   = 3'b011,
    WAIT_OPEN  = 3'b100,
    WAIT_CLOSE = 3'b101,
    ARM_DELAY  = 3'b110,
    ILLEGAL    = 3'b111
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_timer;
  logic [1:0] r_sel;
  logic [1:0] w_sel;
  logic       r_siren;
  logic       r_led;
  logic       w_led;
  logic       w_reload;
  logic       w_load;
  logic       w_expired;
  logic       w_door_any;
  logic [1:0] w_interval;

  function automatic logic is_timed(input state_t s);
    return (s == ARM_DELAY) || (s == TRIGGERED) || (s == ALARM);
  endfunction

  function automatic logic [1:0] code_of(input state_t s, input logic [1:0] sel);
    case (s)
      TRIGGERED: code_of = sel;
      ALARM:     code_of = 2'b11;
      default:   code_of = 2'b00;
    endcase
  endfunction

  assign w_expired  = (r_timer == 4'd0);
  assign w_door_any = bus.driver_door | bus.passenger_door;

  always_comb begin
    w_next   = r_state;
    w_sel    = r_sel;
    w_reload = 1'b0;
    case (r_state)
      DISARMED: begin
        if (!bus.ignition) w_next = WAIT_OPEN;
      end
      WAIT_OPEN: begin
        if (bus.ignition)         w_next = DISARMED;
        else if (bus.driver_door) w_next = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (bus.ignition)          w_next = DISARMED;
        else if (!bus.driver_door) w_next = ARM_DELAY;
      end
      ARM_DELAY: begin
        if (bus.ignition)    w_next = DISARMED;
        else if (w_door_any) w_next = WAIT_CLOSE;
        else if (w_expired)  w_next = ARMED;
      end
      ARMED: begin
        if (bus.driver_door) begin
          w_next = TRIGGERED;
          w_sel  = 2'b01;
        end else if (bus.passenger_door) begin
          w_next = TRIGGERED;
          w_sel  = 2'b10;
        end
      end
      TRIGGERED: begin
        if (bus.ignition)   w_next = DISARMED;
        else if (w_expired) w_next = ALARM;
      end
      ALARM: begin
        if (bus.ignition)    w_next = DISARMED;
        else if (w_door_any) w_reload = 1'b1;
        else if (w_expired)  w_next = ARMED;
      end
      default: w_next = ARMED;
    endcase
  end

  // w_sel tracks r_sel except on the ARMED->TRIGGERED edge, so this covers both
  // the destination code on transitions and the held code otherwise.
  assign w_interval = code_of(w_next, w_sel);
  assign w_load     = w_reload | ((w_next != r_state) & is_timed(w_next));

  always_comb begin
    w_led = 1'b0;
    if (w_next == ARMED)
      w_led = (r_state == ARMED) ? (r_led ^ bus.one_hz_enable) : 1'b0;
    else if (is_timed(w_next))
      w_led = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ARMED;
      r_timer <= 4'd0;
      r_sel   <= 2'b01;
      r_siren <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel;
      r_siren <= (w_next == ALARM);
      r_led   <= w_led;
      if (w_load)
        r_timer <= bus.value;
      else if (bus.one_hz_enable && !w_expired)
        r_timer <= r_timer - 4'd1;
    end
  end

  assign bus.interval   = w_interval;
  assign bus.siren      = r_siren;
  assign bus.status_led = r_led;
  assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed and random stimulus against a behavioural model, scoreboard-checked.
`default_nettype none

module tb_alarm_controller;

  localparam int S_ARMED = 0, S_TRIG = 1, S_ALARM = 2, S_DIS = 3;
  localparam int S_WO = 4, S_WC = 5, S_AD = 6;

  typedef struct {
    logic [2:0] st;
    logic       sir;
    logic       led;
    logic [1:0] itv;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  alarm_controller_if bus();

  alarm_controller dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  // Model state: plain integers and a countdown of remaining ticks.
  int m_st  = S_ARMED;
  int m_cnt = 0;
  int m_sel = 1;
  bit m_led = 1'b0;

  bit         b_ign = 0, b_drv = 0, b_pas = 0;
  logic [3:0] b_val = 4'd0;

  function automatic bit timed(input int s);
    return (s == S_AD) || (s == S_TRIG) || (s == S_ALARM);
  endfunction

  task automatic step(input bit r, input bit ign, input bit drv, input bit pas,
                      input bit tk, input logic [3:0] v);
    int   dest;
    int   nsel;
    bit   reload;
    int   itv;
    exp_t e;
    @(negedge clock);
    reset              = r;
    bus.ignition       = ign;
    bus.driver_door    = drv;
    bus.passenger_door = pas;
    bus.one_hz_enable  = tk;
    bus.value          = v;

    dest = m_st; nsel = m_sel; reload = 0;
    if (m_st == S_DIS) begin
      if (!ign) dest = S_WO;
    end else if (m_st == S_WO) begin
      if (ign) dest = S_DIS; else if (drv) dest = S_WC;
    end else if (m_st == S_WC) begin
      if (ign) dest = S_DIS; else if (!drv) dest = S_AD;
    end else if (m_st == S_AD) begin
      if (ign) dest = S_DIS; else if (drv || pas) dest = S_WC; else if (m_cnt == 0) dest = S_ARMED;
    end else if (m_st == S_ARMED) begin
      if (drv) begin dest = S_TRIG; nsel = 1; end
      else if (pas) begin dest = S_TRIG; nsel = 2; end
    end else if (m_st == S_TRIG) begin
      if (ign) dest = S_DIS; else if (m_cnt == 0) dest = S_ALARM;
    end else begin
      if (ign) dest = S_DIS; else if (drv || pas) reload = 1; else if (m_cnt == 0) dest = S_ARMED;
    end

    if (dest != m_st)
      itv = (dest == S_TRIG) ? nsel : (dest == S_ALARM) ? 3 : 0;
    else
      itv = (m_st == S_TRIG) ? m_sel : (m_st == S_ALARM) ? 3 : 0;

    e.st  = 3'(m_st);
    e.sir = (m_st == S_ALARM);
    e.led = m_led;
    e.itv = 2'(itv);
    q.push_back(e);

    if (r) begin
      m_st = S_ARMED; m_cnt = 0; m_led = 0;
    end else begin
      if (reload || (dest != m_st && timed(dest))) m_cnt = int'(v);
      else if (tk && m_cnt > 0) m_cnt = m_cnt - 1;
      if (dest == S_ARMED) m_led = (m_st == S_ARMED) ? (m_led ^ tk) : 1'b0;
      else m_led = timed(dest);
      m_st  = dest;
      m_sel = nsel;
    end
  endtask

  task automatic cyc(input bit tk);
    step(1'b0, b_ign, b_drv, b_pas, tk, b_val);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, checked 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.state !== e.st) begin
          n_fail++;
          $display("FAIL state: got %0d expected %0d at %0t", bus.state, e.st, $time);
        end
        n_checks++;
        if (bus.siren !== e.sir) begin
          n_fail++;
          $display("FAIL siren: got %0b expected %0b at %0t", bus.siren, e.sir, $time);
        end
        n_checks++;
        if (bus.status_led !== e.led) begin
          n_fail++;
          $display("FAIL status_led: got %0b expected %0b at %0t", bus.status_led, e.led, $time);
        end
        n_checks++;
        if (bus.interval !== e.itv) begin
          n_fail++;
          $display("FAIL interval: got %0d expected %0d at %0t", bus.interval, e.itv, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: stimulus did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.ignition = 0; bus.driver_door = 0; bus.passenger_door = 0;
    bus.one_hz_enable = 0; bus.value = 4'd0;
    repeat (2) @(posedge clock);

    // Reach DISARMED via a trigger, then arm with value 6.
    b_drv = 1; cyc(0);
    b_drv = 0; b_ign = 1; cyc(0); cyc(0);
    b_ign = 0; cyc(0);
    b_drv = 1; cyc(0);
    b_val = 4'd6; b_drv = 0; cyc(0);
    run_ticks(6); cyc(0); cyc(0);

    // Re-arm abort after 3 ticks of the arm delay.
    b_drv = 1; cyc(0); b_drv = 0; b_ign = 1; cyc(0);
    b_ign = 0; cyc(0); b_drv = 1; cyc(0); b_drv = 0; cyc(0);
    run_ticks(3);
    b_pas = 1; cyc(0);
    b_pas = 0; cyc(0);
    run_ticks(6); cyc(0); cyc(0);

    // Both doors together: driver wins; value 8 to alarm, then expire back to ARMED.
    b_drv = 1; b_pas = 1; b_val = 4'd8; cyc(0);
    b_drv = 0; b_pas = 0; run_ticks(8); cyc(0); cyc(0);
    run_ticks(8); cyc(0); cyc(0);

    // Passenger trigger with value 15, disarm after 5 ticks.
    b_pas = 1; b_val = 4'd15; cyc(0);
    b_pas = 0; run_ticks(5);
    b_ign = 1; cyc(0); cyc(0);

    // Arm with value 0: single-cycle arm delay.
    b_ign = 0; cyc(0); b_drv = 1; cyc(0);
    b_val = 4'd0; b_drv = 0; cyc(0); cyc(0); cyc(1); cyc(1);

    // Alarm hold with value 10, door open for 20 ticks, value change mid-count.
    b_drv = 1; b_val = 4'd2; cyc(0);
    b_drv = 0; run_ticks(2);
    b_val = 4'd10; cyc(0);
    b_drv = 1; run_ticks(20);
    b_drv = 0; cyc(1);
    b_val = 4'd3; run_ticks(9); cyc(0); cyc(0);

    // Reset asserted while in ALARM.
    b_pas = 1; b_val = 4'd1; cyc(0);
    b_pas = 0; run_ticks(1); cyc(0); cyc(1);
    step(1'b1, 0, 0, 0, 1, 4'd5);
    cyc(1); cyc(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0, ($urandom % 14) == 0, ($urandom % 9) == 0,
           ($urandom % 11) == 0, ($urandom % 3) == 0, 4'($urandom_range(0, 7)));
    end

    b_ign = 0; b_drv = 0; b_pas = 0; cyc(0);
    @(negedge clock); #4;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
